// File: rtl/or_txn_host_pkg.sv
// Shared types and constants for the OR-combine bus-master sequencer:
// FSM state encoding, target register map and bus widths.
package or_txn_host_pkg;

    localparam int ADDR_W = 3;
    localparam int CNT_W  = 8;

    // Target register map
    localparam logic [ADDR_W-1:0] ADDR_A_ST   = 3'd0;  // bit0 = A FIFO not full
    localparam logic [ADDR_W-1:0] ADDR_B_ST   = 3'd1;  // bit0 = B FIFO not full
    localparam logic [ADDR_W-1:0] ADDR_Y_ST   = 3'd2;  // bit0 = Y FIFO not empty
    localparam logic [ADDR_W-1:0] ADDR_Y_DATA = 3'd3;  // Y head, popped by read_en
    localparam logic [ADDR_W-1:0] ADDR_A_DATA = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_B_DATA = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHK_A  = 3'd1,
        ST_WR_A   = 3'd2,
        ST_CHK_B  = 3'd3,
        ST_WR_B   = 3'd4,
        ST_POLL_Y = 3'd5,
        ST_RD_Y   = 3'd6,
        ST_RESP   = 3'd7
    } state_t;

    // States that poll a status register and are bounded by the wait timer.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_CHK_A) || (s == ST_CHK_B) || (s == ST_POLL_Y);
    endfunction

endpackage

// File: rtl/or_txn_host_if.sv
// Operand/response handshake plus the register-bus of the OR-combine target.
// master = the sequencer, slave = operand source, response sink and target.
interface or_txn_host_if #(
    parameter int WIDTH = 8
);
    logic                                in_valid;
    logic                                in_ready;
    logic [WIDTH-1:0]                    in_a;
    logic [WIDTH-1:0]                    in_b;

    logic                                out_valid;
    logic                                out_ready;
    logic [WIDTH-1:0]                    out_data;
    logic                                out_timeout;
    logic [or_txn_host_pkg::CNT_W-1:0]   done_count;

    logic [or_txn_host_pkg::ADDR_W-1:0]  write_address;
    logic [WIDTH-1:0]                    write_data;
    logic                                write_en;
    logic                                write_rdy;

    logic [or_txn_host_pkg::ADDR_W-1:0]  read_address;
    logic                                read_en;
    logic [WIDTH-1:0]                    read_data;
    logic                                read_rdy;

    modport master (
        input  in_valid, in_a, in_b, out_ready, write_rdy, read_data, read_rdy,
        output in_ready, out_valid, out_data, out_timeout, done_count,
               write_address, write_data, write_en, read_address, read_en
    );

    modport slave (
        output in_valid, in_a, in_b, out_ready, write_rdy, read_data, read_rdy,
        input  in_ready, out_valid, out_data, out_timeout, done_count,
               write_address, write_data, write_en, read_address, read_en
    );

endinterface

// File: rtl/or_wait_timer.sv
// Cycle counter bounding each status-poll state. Held at zero while clr is
// high, counts while en is high, and flags expiry on the TIMEOUT-th cycle.
module or_wait_timer #(
    parameter int TIMEOUT = 600,
    parameter int TO_W    = 10
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    assign expired = (cnt == TO_W'(TIMEOUT - 1));

    // Count cycles spent in a wait state; saturate at the expiry value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/or_txn_host.sv
// Bus-master sequencer for the OR-combine register block. One operand pair
// per transaction: check A space, write A, check B space, write B, poll for
// Y, pop Y, return it. Every wait on a status bit is bounded by a timer; an
// expired wait returns a zero result flagged with out_timeout.
// All bus outputs are registered and loaded with the values of the state
// being entered, so they clear together with the state on reset.
module or_txn_host
    import or_txn_host_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 600,
    parameter int TO_W    = 10
) (
    input  logic          CLK,
    input  logic          RST,
    or_txn_host_if.master bus
);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             tmr_en;
    logic             tmr_clr;
    logic             tmr_expired;
    logic             status_ok;

    // Timer runs only in polling states and is zero on entry to each of them,
    // because every polling state is preceded by a non-polling state.
    assign tmr_en    = is_wait_state(state);
    assign tmr_clr   = !tmr_en;
    assign status_ok = bus.read_data[0];

    or_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Transaction sequencer; strobes default low and are re-asserted for the next state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state             <= ST_IDLE;
            a_q               <= '0;
            b_q               <= '0;
            bus.in_ready      <= 1'b0;
            bus.out_valid     <= 1'b0;
            bus.out_data      <= '0;
            bus.out_timeout   <= 1'b0;
            bus.done_count    <= '0;
            bus.write_en      <= 1'b0;
            bus.write_address <= '0;
            bus.write_data    <= '0;
            bus.read_en       <= 1'b0;
            bus.read_address  <= '0;
        end else begin
            bus.in_ready      <= 1'b0;
            bus.write_en      <= 1'b0;
            bus.write_address <= '0;
            bus.write_data    <= '0;
            bus.read_en       <= 1'b0;
            bus.read_address  <= '0;
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        a_q              <= bus.in_a;
                        b_q              <= bus.in_b;
                        state            <= ST_CHK_A;
                        bus.read_address <= ADDR_A_ST;
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end
                ST_CHK_A: begin
                    if (status_ok) begin
                        state             <= ST_WR_A;
                        bus.write_en      <= 1'b1;
                        bus.write_address <= ADDR_A_DATA;
                        bus.write_data    <= a_q;
                    end else if (tmr_expired) begin
                        state           <= ST_RESP;
                        bus.out_valid   <= 1'b1;
                        bus.out_timeout <= 1'b1;
                        bus.out_data    <= '0;
                    end else begin
                        bus.read_address <= ADDR_A_ST;
                    end
                end
                ST_WR_A: begin
                    if (bus.write_rdy) begin
                        state            <= ST_CHK_B;
                        bus.read_address <= ADDR_B_ST;
                    end else begin
                        bus.write_en      <= 1'b1;
                        bus.write_address <= ADDR_A_DATA;
                        bus.write_data    <= a_q;
                    end
                end
                ST_CHK_B: begin
                    if (status_ok) begin
                        state             <= ST_WR_B;
                        bus.write_en      <= 1'b1;
                        bus.write_address <= ADDR_B_DATA;
                        bus.write_data    <= b_q;
                    end else if (tmr_expired) begin
                        state           <= ST_RESP;
                        bus.out_valid   <= 1'b1;
                        bus.out_timeout <= 1'b1;
                        bus.out_data    <= '0;
                    end else begin
                        bus.read_address <= ADDR_B_ST;
                    end
                end
                ST_WR_B: begin
                    if (bus.write_rdy) begin
                        state            <= ST_POLL_Y;
                        bus.read_address <= ADDR_Y_ST;
                    end else begin
                        bus.write_en      <= 1'b1;
                        bus.write_address <= ADDR_B_DATA;
                        bus.write_data    <= b_q;
                    end
                end
                ST_POLL_Y: begin
                    if (status_ok) begin
                        state            <= ST_RD_Y;
                        bus.read_en      <= 1'b1;
                        bus.read_address <= ADDR_Y_DATA;
                    end else if (tmr_expired) begin
                        state           <= ST_RESP;
                        bus.out_valid   <= 1'b1;
                        bus.out_timeout <= 1'b1;
                        bus.out_data    <= '0;
                    end else begin
                        bus.read_address <= ADDR_Y_ST;
                    end
                end
                ST_RD_Y: begin
                    // Leaving on the accepted cycle keeps it to one pop.
                    if (bus.read_rdy) begin
                        state           <= ST_RESP;
                        bus.out_valid   <= 1'b1;
                        bus.out_timeout <= 1'b0;
                        bus.out_data    <= bus.read_data;
                    end else begin
                        bus.read_en      <= 1'b1;
                        bus.read_address <= ADDR_Y_DATA;
                    end
                end
                ST_RESP: begin
                    if (bus.out_ready) begin
                        state         <= ST_IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        if (!bus.out_timeout) begin
                            bus.done_count <= bus.done_count + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_or_txn_host.sv
// Bench for or_txn_host: behavioural OR-combine target, scoreboarded responses.
module tb_or_txn_host;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 600;
    localparam int TO_W    = 10;

    typedef struct {
        logic [7:0] data;
        logic       to;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int model_done = 0;

    exp_t       exp_q[$];
    logic [7:0] y_pending[$];

    // target model controls and state
    logic       a_block = 1'b0;
    logic       y_hold  = 1'b0;
    logic       rand_bp = 1'b0;
    int         or_mode = 1;        // 0 low, 1 high, 2 random
    logic       wr_rdy;
    logic       rd_rdy;
    logic       a_has, b_has;
    logic [7:0] a_val, b_val;
    logic [7:0] ymem [0:7];
    logic [7:0] y_wr, y_rd;
    logic [3:0] cdly;
    logic [2:0] wlog_addr [0:63];
    logic [7:0] wlog_data [0:63];
    logic [5:0] wlog_n = '0;
    logic [7:0] rd_mux;

    or_txn_host_if #(.WIDTH(WIDTH)) bus ();

    or_txn_host #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    assign bus.write_rdy = wr_rdy;
    assign bus.read_rdy  = rd_rdy;
    assign bus.read_data = rd_mux;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Target: register-mapped A/B FIFOs (depth 1) combining into a Y FIFO after a random delay.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_has <= 1'b0;
            b_has <= 1'b0;
            y_wr  <= '0;
            y_rd  <= '0;
            cdly  <= '0;
        end else begin
            if (bus.write_en && bus.write_rdy) begin
                wlog_addr[wlog_n] <= bus.write_address;
                wlog_data[wlog_n] <= bus.write_data;
                wlog_n <= wlog_n + 1'b1;
                if (bus.write_address == 3'd4) begin
                    a_has <= 1'b1;
                    a_val <= bus.write_data;
                end else if (bus.write_address == 3'd5) begin
                    b_has <= 1'b1;
                    b_val <= bus.write_data;
                end
            end
            if (a_has && b_has) begin
                if (cdly == 4'd0) begin
                    ymem[y_wr[2:0]] <= a_val | b_val;
                    y_wr  <= y_wr + 1'b1;
                    a_has <= 1'b0;
                    b_has <= 1'b0;
                    cdly  <= 4'($urandom_range(0, 12));
                end else begin
                    cdly <= cdly - 1'b1;
                end
            end
            if (bus.read_en && bus.read_rdy && bus.read_address == 3'd3) begin
                y_rd <= y_rd + 1'b1;
            end
        end
    end

    // Target read port: combinational from the address.
    always_comb begin
        rd_mux = '0;
        case (bus.read_address)
            3'd0:    rd_mux[0] = !a_has && !a_block;
            3'd1:    rd_mux[0] = !b_has;
            3'd2:    rd_mux[0] = (y_wr != y_rd) && !y_hold;
            3'd3:    rd_mux = ymem[y_rd[2:0]];
            default: rd_mux = '0;
        endcase
    end

    // Ready/backpressure driver.
    initial begin
        bus.out_ready = 1'b1;
        wr_rdy = 1'b1;
        rd_rdy = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            wr_rdy = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_rdy = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            case (or_mode)
                0:       bus.out_ready = 1'b0;
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Response monitor: compare each handshake against the oldest expectation.
    always @(negedge CLK) begin
        if (RST) begin
            model_done <= 0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got data %0h, required no response", bus.out_data);
            end else begin
                check("resp_data", 32'(bus.out_data), 32'(exp_q[0].data));
                check("resp_timeout", 32'(bus.out_timeout), 32'(exp_q[0].to));
                if (!exp_q[0].to) model_done <= model_done + 1;
                exp_q.delete(0);
            end
        end
    end

    // Bus protocol watch.
    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.read_en && bus.read_address != 3'd3) begin
                errors++;
                $display("FAIL read_en_addr: got address %0d, required 3", bus.read_address);
            end
            if (!bus.write_en && (bus.write_address != 3'd0 || bus.write_data != 8'd0)) begin
                errors++;
                $display("FAIL idle_write_bus: got %0d/%0h, required 0/0", bus.write_address, bus.write_data);
            end
            if (bus.write_en && bus.write_address != 3'd4 && bus.write_address != 3'd5) begin
                errors++;
                $display("FAIL write_addr: got %0d, required 4 or 5", bus.write_address);
            end
        end
    end

    initial begin
        repeat (80000) @(posedge CLK);
        $display("FAIL watchdog: got no finish, required finish within 80000 cycles");
        $fatal(1, "watchdog");
    end

    // Offer one pair; the expectation is queued at issue time.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit y_to);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.in_ready && n < 2000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL in_ready_wait: got 0, required 1 within 2000 cycles");
            return;
        end
        y_pending.push_back(a | b);
        if (y_to) begin
            e.data = 8'h00;
            e.to   = 1'b1;
        end else begin
            e.data = y_pending.pop_front();
            e.to   = 1'b0;
        end
        exp_q.push_back(e);
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && bus.in_ready) && n < 3000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (n >= 3000) begin
            errors++;
            $display("FAIL idle_wait: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic wait_out_valid(input int limit);
        int n;
        n = 0;
        while (!bus.out_valid && n < limit) begin
            @(posedge CLK);
            #1;
            n++;
        end
    endtask

    initial begin
        int n, wcount, t0, t1;
        logic [7:0] ra, rb;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;

        // 1: reset state, then a basic transaction
        #3 RST = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_write_en", 32'(bus.write_en), 0);
        check("rst_read_en", 32'(bus.read_en), 0);
        check("rst_done_count", 32'(bus.done_count), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("in_ready_before_edge", 32'(bus.in_ready), 0);
        @(posedge CLK);
        #1;
        check("in_ready_after_edge", 32'(bus.in_ready), 1);
        send(8'h0F, 8'hF0, 1'b0);
        wait_idle();
        check("wlog_count", 32'(wlog_n), 2);
        check("wlog0_addr", 32'(wlog_addr[0]), 4);
        check("wlog0_data", 32'(wlog_data[0]), 32'h0F);
        check("wlog1_addr", 32'(wlog_addr[1]), 5);
        check("wlog1_data", 32'(wlog_data[1]), 32'hF0);
        check("done_after_t1", 32'(bus.done_count), 1);

        // 2: A full for 20 cycles
        a_block = 1'b1;
        send(8'hA5, 8'h18, 1'b0);
        wcount = 0;
        repeat (20) begin
            if (bus.write_en) wcount++;
            @(posedge CLK);
            #1;
        end
        check("blocked_writes", 32'(wcount), 0);
        a_block = 1'b0;
        @(posedge CLK);
        #1;
        check("a_write_en", 32'(bus.write_en), 1);
        check("a_write_addr", 32'(bus.write_address), 4);
        check("a_write_data", 32'(bus.write_data), 32'hA5);
        wait_idle();

        // 3: Y never visible -> timeout TIMEOUT cycles after POLL_Y entry
        y_hold = 1'b1;
        t0 = model_done;
        send(8'h33, 8'h44, 1'b1);
        n = 0;
        while (bus.read_address != 3'd2 && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("reach_poll_y_t3", 32'(bus.read_address), 2);
        t1 = cyc;
        wait_out_valid(1000);
        check("timeout_latency", 32'(cyc - t1), TIMEOUT);
        wait_idle();
        check("done_unchanged", 32'(bus.done_count), 32'(t0));
        y_hold = 1'b0;

        // 4: response backpressure (returns the Y left behind by the timeout)
        or_mode = 0;
        send(8'h5A, 8'h81, 1'b0);
        wait_out_valid(2000);
        repeat (5) begin
            @(posedge CLK);
            #1;
            check("hold_valid", 32'(bus.out_valid), 1);
            check("hold_data", 32'(bus.out_data), 32'(exp_q[0].data));
            check("hold_quiet", 32'({bus.in_ready, bus.write_en, bus.read_en}), 0);
        end
        or_mode = 1;
        wait_idle();

        // 5: reset while polling Y
        send(8'h10, 8'h20, 1'b0);
        n = 0;
        while (bus.read_address != 3'd2 && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("reach_poll_y_t5", 32'(bus.read_address), 2);
        RST = 1'b1;
        #1;
        check("rst_poll_read_en", 32'(bus.read_en), 0);
        check("rst_poll_write_en", 32'(bus.write_en), 0);
        check("rst_poll_addr", 32'(bus.read_address), 0);
        exp_q.delete();
        y_pending.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("in_ready_after_rst", 32'(bus.in_ready), 1);
        send(8'h01, 8'h02, 1'b0);
        wait_idle();
        check("done_after_t5", 32'(bus.done_count), 1);

        // 6: three back-to-back pairs from a fresh reset
        RST = 1'b1;
        #1;
        exp_q.delete();
        y_pending.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        send(8'h11, 8'h22, 1'b0);
        send(8'h80, 8'h01, 1'b0);
        send(8'h0C, 8'hC0, 1'b0);
        wait_idle();
        check("done_count_3", 32'(bus.done_count), 3);

        // random pairs with bus and response backpressure
        rand_bp = 1'b1;
        or_mode = 2;
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            send(ra, rb, 1'b0);
        end
        wait_idle();
        check("done_count_rand", 32'(bus.done_count), 32'(model_done));
        check("done_count_15", 32'(bus.done_count), 15);
        rand_bp = 1'b0;
        or_mode = 1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
